// File: rtl/led_pwm_monitor_if.sv
// led_pwm_monitor_if
//   Result bundle of the LED PWM monitor, N channels wide.
//   o_lumin_value : recovered 8-bit value, channel k at [8k+7:8k]
//   o_valid       : per-channel update strobe
//   o_period_err  : last closed period was outside nominal +/- tolerance
//   o_stuck_high  : line held high for two nominal periods
//   o_stuck_low   : line held low for two nominal periods
//   dbg_state     : per-channel FSM state, channel k at [2k+1:2k]
//
//   Handshake: o_valid[k] is a single-cycle strobe with no ready/back-pressure.
//   o_lumin_value[k] changes only in the cycle o_valid[k] is high and is stable
//   otherwise; a consumer that wants the value must capture it on that strobe.
interface led_pwm_monitor_if #(
    parameter int N = 4
);
    logic [8*N-1:0] o_lumin_value;
    logic [N-1:0]   o_valid;
    logic [N-1:0]   o_period_err;
    logic [N-1:0]   o_stuck_high;
    logic [N-1:0]   o_stuck_low;
    logic [2*N-1:0] dbg_state;

    modport master (
        output o_lumin_value, o_valid, o_period_err, o_stuck_high, o_stuck_low, dbg_state
    );
    modport slave (
        input o_lumin_value, o_valid, o_period_err, o_stuck_high, o_stuck_low, dbg_state
    );
endinterface

// File: rtl/led_pwm_monitor.sv
// led_pwm_monitor
//   Receive-side monitor for the LED PWM drive path. For each line it measures
//   the high time of every PWM period, converts it back into the 8-bit value the
//   driver was given, and flags periods of the wrong length and stuck lines.
// Ports
//   i_clk  : system clock
//   i_srst : asynchronous active-high reset, released synchronously upstream
//   i_pwm  : PWM lines, asynchronous to i_clk
//   mon    : result bundle (values, strobes, fault flags, FSM state)
module led_pwm_monitor #(
    parameter int parm_channel_count           = 4,
    parameter int parm_FCLK                    = 40_000_000,
    parameter int parm_pwm_period_milliseconds = 10,
    parameter int parm_max_duty_tenths         = 9
) (
    input  logic                          i_clk,
    input  logic                          i_srst,
    input  logic [parm_channel_count-1:0] i_pwm,
    led_pwm_monitor_if.master             mon
);
    localparam int N        = parm_channel_count;
    localparam int C_PERIOD = parm_FCLK / 1000 * parm_pwm_period_milliseconds;
    localparam int C_RATIO  = (C_PERIOD / 10 * parm_max_duty_tenths) / 256;
    localparam int C_TOL    = C_PERIOD / 64;
    localparam int CW_MIN   = $clog2(2 * C_PERIOD + 1);
    localparam int CW       = (CW_MIN > 21) ? CW_MIN : 21;
    localparam int PW       = (C_RATIO > 2) ? $clog2(C_RATIO) : 1;

    localparam logic [CW-1:0] P_MIN     = CW'(C_PERIOD - C_TOL);
    localparam logic [CW-1:0] P_MAX     = CW'(C_PERIOD + C_TOL);
    localparam logic [CW-1:0] STUCK_CNT = CW'(2 * C_PERIOD);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PRE_INIT  = PW'(C_RATIO / 2);
    localparam logic [PW-1:0] PRE_TOP   = PW'(C_RATIO - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_STUCK} state_t;

    // Two-flop synchronizer plus one edge-detect stage per line.
    logic [N-1:0] sync1, sync2, prev;
    logic [N-1:0] rise, fall;

    always_ff @(posedge i_clk or posedge i_srst) begin
        if (i_srst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= i_pwm;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [PW-1:0] pre_q, pre_d;
        logic [7:0]    acc_q, acc_d;
        logic          lvl_q, lvl_d;    // line level when the stuck state was entered
        logic          skip_q, skip_d;  // current period must not be published
        logic [7:0]    val_q, val_d;
        logic          vld_q, vld_d;
        logic          perr_q, perr_d;
        logic          sh_q, sh_d;
        logic          sl_q, sl_d;

        // High-time accumulation: prescale starts at half a step so acc rounds
        // to nearest instead of truncating.
        logic          pre_wrap;
        logic [PW-1:0] pre_next;
        logic [7:0]    acc_next;
        logic          in_range;

        assign pre_wrap = (pre_q == PRE_TOP);
        assign pre_next = pre_wrap ? '0 : pre_q + 1'b1;
        assign acc_next = (pre_wrap && acc_q != 8'hFF) ? acc_q + 8'd1 : acc_q;
        assign in_range = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);

        always_ff @(posedge i_clk or posedge i_srst) begin
            if (i_srst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pre_q   <= '0;
                acc_q   <= '0;
                lvl_q   <= 1'b0;
                skip_q  <= 1'b0;
                val_q   <= '0;
                vld_q   <= 1'b0;
                perr_q  <= 1'b0;
                sh_q    <= 1'b0;
                sl_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pre_q   <= pre_d;
                acc_q   <= acc_d;
                lvl_q   <= lvl_d;
                skip_q  <= skip_d;
                val_q   <= val_d;
                vld_q   <= vld_d;
                perr_q  <= perr_d;
                sh_q    <= sh_d;
                sl_q    <= sl_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pre_d   = pre_q;
            acc_d   = acc_q;
            lvl_d   = lvl_q;
            skip_d  = skip_q;
            val_d   = val_q;
            vld_d   = 1'b0;
            perr_d  = perr_q;
            sh_d    = sh_q;
            sl_d    = sl_q;

            unique case (state_q)
                S_IDLE: begin
                    if (rise[g]) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                        pre_d   = PRE_INIT;
                        acc_d   = '0;
                        skip_d  = 1'b0;
                    end
                end
                S_HIGH: begin
                    if (fall[g]) begin
                        // The fall-detect clock still counts as high time: it
                        // stands in for the rise-detect clock, which did not.
                        state_d = S_LOW;
                        cnt_d   = cnt_q + 1'b1;
                        pre_d   = pre_next;
                        acc_d   = acc_next;
                    end else if (cnt_q >= STUCK_CNT) begin
                        state_d = S_STUCK;
                        lvl_d   = 1'b1;
                        sh_d    = 1'b1;
                        val_d   = 8'hFF;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        pre_d   = pre_next;
                        acc_d   = acc_next;
                    end
                end
                S_LOW: begin
                    if (rise[g]) begin
                        // cnt_q holds the full period length at this point.
                        if (!skip_q) begin
                            if (in_range) begin
                                val_d  = acc_q;
                                vld_d  = 1'b1;
                                perr_d = 1'b0;
                                sh_d   = 1'b0;
                                sl_d   = 1'b0;
                            end else begin
                                perr_d = 1'b1;
                            end
                        end
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                        pre_d   = PRE_INIT;
                        acc_d   = '0;
                        skip_d  = 1'b0;
                    end else if (cnt_q >= STUCK_CNT) begin
                        state_d = S_STUCK;
                        lvl_d   = 1'b0;
                        sl_d    = 1'b1;
                        val_d   = 8'h00;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_STUCK: begin
                    if (!lvl_q && rise[g]) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                        pre_d   = PRE_INIT;
                        acc_d   = '0;
                        skip_d  = 1'b0;
                    end else if (lvl_q && fall[g]) begin
                        // The period started by this fall has no measured high
                        // phase, so it is closed but never published.
                        state_d = S_LOW;
                        cnt_d   = CNT_ONE;
                        pre_d   = '0;
                        acc_d   = '0;
                        skip_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        assign mon.o_lumin_value[8*g +: 8] = val_q;
        assign mon.o_valid[g]              = vld_q;
        assign mon.o_period_err[g]         = perr_q;
        assign mon.o_stuck_high[g]         = sh_q;
        assign mon.o_stuck_low[g]          = sl_q;
        assign mon.dbg_state[2*g +: 2]     = state_q;
    end
endmodule

// File: tb/tb_led_pwm_monitor.sv
// tb_led_pwm_monitor
//   Drives random PWM periods on every channel in parallel and compares the
//   monitor results against a period-level reference model. Scaled clock so
//   that one nominal period is 2560 clocks, step 9 clocks, tolerance 40.
module tb_led_pwm_monitor;
    localparam int N     = 4;
    localparam int FCLK  = 2_560_000;
    localparam int PMS   = 1;
    localparam int DUTY  = 9;
    localparam int C     = FCLK / 1000 * PMS;
    localparam int R     = (C / 10 * DUTY) / 256;
    localparam int TOL   = C / 64;
    localparam int CHK   = 6;
    localparam int N_SEG = 14;

    logic         i_clk = 1'b0;
    logic         i_srst;
    logic [N-1:0] i_pwm;
    logic         pwm_b [N];

    int n_checks = 0;
    int n_errors = 0;
    int vcnt [N];

    // Reference model state, one entry per channel.
    int exp_val [N];
    int exp_vc  [N];
    bit exp_perr[N];
    bit exp_sh  [N];
    bit exp_sl  [N];
    bit meas    [N];
    int prev_h  [N];
    int prev_l  [N];

    // Boundary periods for channel 0: (high, period)
    int bnd_h [6] = '{1280, 1, 700, 900, C - 30, 1152};
    int bnd_p [6] = '{C + TOL, C - TOL, C + TOL + 1, C - TOL - 1, C, C};

    led_pwm_monitor_if #(.N(N)) mon_if ();

    led_pwm_monitor #(
        .parm_channel_count          (N),
        .parm_FCLK                   (FCLK),
        .parm_pwm_period_milliseconds(PMS),
        .parm_max_duty_tenths        (DUTY)
    ) dut (
        .i_clk (i_clk),
        .i_srst(i_srst),
        .i_pwm (i_pwm),
        .mon   (mon_if)
    );

    // Clock and reset-related plumbing
    always #5 i_clk = ~i_clk;

    always_comb begin
        for (int i = 0; i < N; i++) i_pwm[i] = pwm_b[i];
    end

    always @(negedge i_clk or posedge i_srst) begin
        if (i_srst) begin
            for (int i = 0; i < N; i++) vcnt[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (mon_if.o_valid[i] === 1'b1) vcnt[i] <= vcnt[i] + 1;
        end
    end

    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            exp_val[k] = 0; exp_vc[k] = 0; exp_perr[k] = 0;
            exp_sh[k] = 0; exp_sl[k] = 0; meas[k] = 0;
            prev_h[k] = 0; prev_l[k] = 0;
        end
    endtask

    // Called at each pin rising edge; settles the period that edge closes.
    task automatic model_rise(input int k, input int h_new, input int l_new);
        int h, p, v;
        if (meas[k]) begin
            h = prev_h[k];
            p = prev_h[k] + prev_l[k];
            if (h > 2 * C) begin
                exp_val[k] = 255; exp_sh[k] = 1; exp_vc[k]++;
            end else if (p > 2 * C) begin
                exp_val[k] = 0; exp_sl[k] = 1; exp_vc[k]++;
            end else if (p >= C - TOL && p <= C + TOL) begin
                v = (2 * h + R) / (2 * R);
                exp_val[k] = (v > 255) ? 255 : v;
                exp_vc[k]++;
                exp_perr[k] = 0; exp_sh[k] = 0; exp_sl[k] = 0;
            end else begin
                exp_perr[k] = 1;
            end
        end
        meas[k]   = 1;
        prev_h[k] = h_new;
        prev_l[k] = l_new;
    endtask

    task automatic check_chan(input int k, input string where);
        logic [7:0] v;
        v = mon_if.o_lumin_value[8*k +: 8];
        check($sformatf("ch%0d %s value", k, where), 32'(v), exp_val[k]);
        check($sformatf("ch%0d %s valid_count", k, where), vcnt[k], exp_vc[k]);
        check($sformatf("ch%0d %s period_err", k, where), 32'(mon_if.o_period_err[k]), 32'(exp_perr[k]));
        check($sformatf("ch%0d %s stuck_high", k, where), 32'(mon_if.o_stuck_high[k]), 32'(exp_sh[k]));
        check($sformatf("ch%0d %s stuck_low", k, where), 32'(mon_if.o_stuck_low[k]), 32'(exp_sl[k]));
    endtask

    // Driver: one period of h high clocks then l low clocks; the outputs of the
    // period closed by this rising edge are checked CHK clocks later.
    task automatic drive_segment(input int k, input int h, input int l, input string where);
        @(negedge i_clk);
        pwm_b[k] = 1'b1;
        model_rise(k, h, l);
        for (int i = 1; i < h + l; i++) begin
            @(negedge i_clk);
            if (i == h) pwm_b[k] = 1'b0;
            if (i == CHK) check_chan(k, where);
        end
    endtask

    task automatic run_channel(input int k, input int nseg, input bit full);
        int h, p;
        for (int s = 0; s < nseg; s++) begin
            if (full && k == 0 && s >= 1 && s <= 6) begin
                h = bnd_h[s-1];
                p = bnd_p[s-1];
            end else if (full && s == 7) begin
                h = int'($urandom_range(C / 2, 1));
                p = h + 2 * C + int'($urandom_range(400, 100));
            end else if (full && s == 10) begin
                h = 2 * C + int'($urandom_range(400, 100));
                p = h + int'($urandom_range(C / 2, 200));
            end else if ($urandom_range(3, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) p = C + TOL + int'($urandom_range(500, 1));
                else                           p = C - TOL - int'($urandom_range(500, 1));
                h = int'($urandom_range(p - 1, 1));
            end else begin
                p = C - TOL + int'($urandom_range(2 * TOL, 0));
                if ($urandom_range(4, 0) == 0) h = int'($urandom_range(20, 1));
                else                           h = int'($urandom_range(p - 1, 1));
            end
            drive_segment(k, h, p - h, $sformatf("seg%0d", s));
        end
    endtask

    initial begin
        i_srst = 1'b1;
        for (int k = 0; k < N; k++) pwm_b[k] = 1'b0;
        model_reset();
        repeat (4) @(negedge i_clk);
        check("reset lumin_value", mon_if.o_lumin_value, 32'd0);
        check("reset valid", 32'(mon_if.o_valid), 32'd0);
        check("reset period_err", 32'(mon_if.o_period_err), 32'd0);
        check("reset stuck_high", 32'(mon_if.o_stuck_high), 32'd0);
        check("reset stuck_low", 32'(mon_if.o_stuck_low), 32'd0);
        i_srst = 1'b0;

        for (int k = 0; k < N; k++) begin
            fork
                automatic int kk = k;
                run_channel(kk, N_SEG, 1'b1);
            join_none
        end
        wait fork;

        // Reset asserted while every line is in its high phase.
        @(negedge i_clk);
        for (int k = 0; k < N; k++) pwm_b[k] = 1'b1;
        repeat (20) @(negedge i_clk);
        #2 i_srst = 1'b1;
        #1;
        check("midhigh reset lumin_value", mon_if.o_lumin_value, 32'd0);
        check("midhigh reset period_err", 32'(mon_if.o_period_err), 32'd0);
        check("midhigh reset stuck_high", 32'(mon_if.o_stuck_high), 32'd0);
        check("midhigh reset stuck_low", 32'(mon_if.o_stuck_low), 32'd0);
        check("midhigh reset valid", 32'(mon_if.o_valid), 32'd0);
        for (int k = 0; k < N; k++) pwm_b[k] = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_srst = 1'b0;

        for (int k = 0; k < N; k++) begin
            fork
                automatic int kk = k;
                run_channel(kk, 3, 1'b0);
            join_none
        end
        wait fork;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
